// File: rtl/udma_spim_reg_if_mc_pkg.sv
// ---------------------------------------------------------------------------
// udma_spim_mc_pkg
// Shared definitions for the multi-channel uDMA SPI master register interface:
// cfg-bus word offsets, channel window stride, uDMA setup command codes and the
// packed entry type stored in the setup-command queue.
// ---------------------------------------------------------------------------
package udma_spim_mc_pkg;

  localparam int CFG_AW    = 5;  // cfg bus word-address width
  localparam int CH_STRIDE = 4;  // words per channel register window

  // Offsets inside a channel window
  localparam logic [1:0] REG_SADDR = 2'd0;
  localparam logic [1:0] REG_SIZE  = 2'd1;
  localparam logic [1:0] REG_CFG   = 2'd2;

  // Global registers
  localparam logic [4:0] REG_STATUS = 5'h10;
  localparam logic [4:0] REG_EVT    = 5'h11;
  localparam logic [4:0] REG_EVT_EN = 5'h12;

  // uDMA command-stream setup codes (bits [31:28] of the command word)
  localparam logic [3:0] SPI_CMD_SETUP_UCA = 4'hD;
  localparam logic [3:0] SPI_CMD_SETUP_UCS = 4'hE;

  // Default widths of the address and size fields carried by the queue
  localparam int DEF_L2_AWIDTH  = 12;
  localparam int DEF_TRANS_SIZE = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One payload field serves both UCA (address) and UCS (size); the top
  // module slices it down to the width each destination needs.
  localparam int PAYLOAD_W = max_int(DEF_L2_AWIDTH, DEF_TRANS_SIZE);

  typedef struct packed {
    logic                 uca;      // 1 = address setup, 0 = size setup
    logic [1:0]           ch;
    logic [1:0]           ds;
    logic [PAYLOAD_W-1:0] payload;
  } q_entry_t;

endpackage

// File: rtl/udma_spim_reg_if_mc_if.sv
// ---------------------------------------------------------------------------
// udma_spim_reg_if_mc_if
// Bundles the cfg (APB-like) register bus and the uDMA command stream.
//   master : drives cfg requests and command words, receives read data/ready
//   slave  : the register interface block
// ---------------------------------------------------------------------------
interface udma_spim_reg_if_mc_if;
  import udma_spim_mc_pkg::*;

  logic [31:0]       cfg_data_i;
  logic [CFG_AW-1:0] cfg_addr_i;
  logic              cfg_valid_i;
  logic              cfg_rwn_i;
  logic [31:0]       cfg_data_o;
  logic              cfg_ready_o;

  logic [31:0]       udma_cmd_i;
  logic              udma_cmd_valid_i;
  logic              udma_cmd_ready_i;
  logic              udma_cmd_ready_o;

  modport master (
    output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
    output udma_cmd_i, udma_cmd_valid_i, udma_cmd_ready_i,
    input  cfg_data_o, cfg_ready_o, udma_cmd_ready_o
  );

  modport slave (
    input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
    input  udma_cmd_i, udma_cmd_valid_i, udma_cmd_ready_i,
    output cfg_data_o, cfg_ready_o, udma_cmd_ready_o
  );
endinterface

// File: rtl/udma_spim_reg_if_mc_cmd_fifo.sv
// ---------------------------------------------------------------------------
// udma_spim_cmd_fifo
// Generic synchronous FIFO, first-word-fall-through (head visible on data_o
// whenever empty_o is low).
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push_i / data_i     : write request and data (ignored when full)
//   pop_i               : drop the head entry (ignored when empty)
//   flush_i             : discard all entries; overrides push/pop
//   data_o              : head entry
//   full_o, empty_o     : status
//   count_o             : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module udma_spim_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever observed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/udma_spim_reg_if_mc.sv
// ---------------------------------------------------------------------------
// udma_spim_reg_if_mc
// Multi-channel register interface for the uDMA SPI master.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   bus (slave modport)    : cfg register bus + uDMA command stream
//   cfg_*_o                : per-channel setup towards the uDMA channels
//                            (en/clr are single-cycle pulses)
//   cfg_en_i/pending_i/... : per-channel status from the uDMA channels
//   status_i               : SPI core status, visible in STATUS
//   irq_o                  : registered OR of enabled sticky done events
// UCA/UCS setup commands are queued in order; a UCS waits until its channel
// is idle and its guard counter has expired, then loads size/datasize and
// pulses cfg_en_o. Payload slicing assumes L2_AWIDTH_NOAL and TRANS_SIZE do
// not exceed PAYLOAD_W.
// ---------------------------------------------------------------------------
module udma_spim_reg_if_mc
  import udma_spim_mc_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int NUM_CH         = 3,
  parameter int Q_DEPTH        = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  udma_spim_reg_if_mc_if.slave                  bus,
  output logic [NUM_CH-1:0][L2_AWIDTH_NOAL-1:0] cfg_startaddr_o,
  output logic [NUM_CH-1:0][TRANS_SIZE-1:0]     cfg_size_o,
  output logic [NUM_CH-1:0][1:0]                cfg_datasize_o,
  output logic [NUM_CH-1:0]                     cfg_continuous_o,
  output logic [NUM_CH-1:0]                     cfg_en_o,
  output logic [NUM_CH-1:0]                     cfg_clr_o,
  output logic [NUM_CH-1:0]                     cfg_backpressure_o,
  input  logic [NUM_CH-1:0]                     cfg_en_i,
  input  logic [NUM_CH-1:0]                     cfg_pending_i,
  input  logic [NUM_CH-1:0][L2_AWIDTH_NOAL-1:0] cfg_curr_addr_i,
  input  logic [NUM_CH-1:0][TRANS_SIZE-1:0]     cfg_bytes_left_i,
  input  logic [1:0]                            status_i,
  output logic                                  irq_o
);
  localparam int CNT_W = $clog2(Q_DEPTH) + 1;

  // Register state
  logic [NUM_CH-1:0][L2_AWIDTH_NOAL-1:0] startaddr_q, startaddr_d;
  logic [NUM_CH-1:0][TRANS_SIZE-1:0]     size_q, size_d;
  logic [NUM_CH-1:0][1:0]                ds_q, ds_d;
  logic [NUM_CH-1:0][1:0]                guard_q, guard_d;
  logic [NUM_CH-1:0] cont_q, cont_d, bp_q, bp_d, en_q, en_d, clr_q, clr_d;
  logic [NUM_CH-1:0] evt_q, evt_d, evt_en_q, evt_en_d, en_prev_q;
  logic              irq_q, irq_d;

  // Queue
  q_entry_t         push_entry, head;
  logic             push, pop, flush, full, empty;
  logic [CNT_W-1:0] count;

  // Decode
  logic [3:0]        cmd_code;
  logic              cmd_is_uca, cmd_is_ucs, cmd_accept;
  logic              wr_req, wr, conflict;
  logic [NUM_CH-1:0] hit_saddr, hit_size, hit_cfg, head_sel, guard_busy;
  logic [NUM_CH-1:0] uca_pop_sel, ucs_pop_sel;
  logic [31:0]       wdata, rdata;
  logic              unused_bits;

  assign wdata      = bus.cfg_data_i;
  assign cmd_code   = bus.udma_cmd_i[31:28];
  assign cmd_is_uca = (cmd_code == SPI_CMD_SETUP_UCA);
  assign cmd_is_ucs = (cmd_code == SPI_CMD_SETUP_UCS);
  assign cmd_accept = bus.udma_cmd_valid_i & bus.udma_cmd_ready_i & ~full;
  assign bus.udma_cmd_ready_o = ~full;

  // Commands for non-existent channels are consumed but never queued, so
  // every queued entry refers to a real channel.
  assign push = cmd_accept & (cmd_is_uca | cmd_is_ucs) &
                (int'(bus.udma_cmd_i[27:26]) < NUM_CH);

  always_comb begin
    push_entry         = '0;
    push_entry.uca     = cmd_is_uca;
    push_entry.ch      = bus.udma_cmd_i[27:26];
    push_entry.ds      = bus.udma_cmd_i[25:24];
    push_entry.payload = bus.udma_cmd_i[PAYLOAD_W-1:0];
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign hit_saddr[gi]  = (bus.cfg_addr_i == CFG_AW'(CH_STRIDE*gi + int'(REG_SADDR)));
    assign hit_size[gi]   = (bus.cfg_addr_i == CFG_AW'(CH_STRIDE*gi + int'(REG_SIZE)));
    assign hit_cfg[gi]    = (bus.cfg_addr_i == CFG_AW'(CH_STRIDE*gi + int'(REG_CFG)));
    assign head_sel[gi]   = ~empty & (head.ch == 2'(gi));
    assign guard_busy[gi] = (guard_q[gi] != 2'd0);
  end

  // UCA never waits; UCS waits for its channel to be idle and unguarded.
  assign pop = ~empty & (head.uca | (|(head_sel & ~cfg_pending_i & ~guard_busy)));
  assign uca_pop_sel = head_sel & {NUM_CH{pop & head.uca}};
  assign ucs_pop_sel = head_sel & {NUM_CH{pop & ~head.uca}};

  // A CFG write always carries datasize, so it collides with any UCS pop
  // to the same channel.
  assign conflict = |(uca_pop_sel & hit_saddr) | |(ucs_pop_sel & (hit_size | hit_cfg));
  assign wr_req   = bus.cfg_valid_i & ~bus.cfg_rwn_i;
  assign bus.cfg_ready_o = ~(wr_req & (cmd_accept | conflict));
  assign wr    = wr_req & bus.cfg_ready_o;
  assign flush = wr & (|hit_cfg) & wdata[6];

  udma_spim_cmd_fifo #(.W($bits(q_entry_t)), .DEPTH(Q_DEPTH)) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    startaddr_d = startaddr_q;
    size_d      = size_q;
    ds_d        = ds_q;
    cont_d      = cont_q;
    bp_d        = bp_q;
    en_d        = '0;
    clr_d       = '0;
    guard_d     = guard_q;
    evt_d       = evt_q;
    evt_en_d    = evt_en_q;
    irq_d       = |(evt_q & evt_en_q);
    for (int c = 0; c < NUM_CH; c++) begin
      if (guard_busy[c]) guard_d[c] = guard_q[c] - 2'd1;
      if (wr & hit_saddr[c]) startaddr_d[c] = wdata[L2_AWIDTH_NOAL-1:0];
      if (wr & hit_size[c])  size_d[c] = wdata[TRANS_SIZE-1:0];
      if (wr & hit_cfg[c]) begin
        bp_d[c]   = wdata[7];
        clr_d[c]  = wdata[6];
        en_d[c]   = wdata[4];
        ds_d[c]   = wdata[2:1];
        cont_d[c] = wdata[0];
      end
      if (uca_pop_sel[c]) startaddr_d[c] = head.payload[L2_AWIDTH_NOAL-1:0];
      if (ucs_pop_sel[c]) begin
        size_d[c]  = head.payload[TRANS_SIZE-1:0];
        ds_d[c]    = head.ds;
        en_d[c]    = 1'b1;
        // Covers the cycles before the channel reflects the new transfer
        // on cfg_pending_i.
        guard_d[c] = 2'd2;
      end
      if (flush) guard_d[c] = 2'd0;
      // W1C first so a simultaneous done event survives the clear.
      if (wr & (bus.cfg_addr_i == REG_EVT) & wdata[c]) evt_d[c] = 1'b0;
      if (en_prev_q[c] & ~cfg_en_i[c] & ~cfg_pending_i[c]) evt_d[c] = 1'b1;
    end
    if (wr & (bus.cfg_addr_i == REG_EVT_EN)) evt_en_d = wdata[NUM_CH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      startaddr_q <= '0;
      size_q      <= '0;
      ds_q        <= {NUM_CH{2'b10}};
      cont_q      <= '0;
      bp_q        <= '0;
      en_q        <= '0;
      clr_q       <= '0;
      guard_q     <= '0;
      evt_q       <= '0;
      evt_en_q    <= '0;
      en_prev_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      startaddr_q <= startaddr_d;
      size_q      <= size_d;
      ds_q        <= ds_d;
      cont_q      <= cont_d;
      bp_q        <= bp_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      guard_q     <= guard_d;
      evt_q       <= evt_d;
      evt_en_q    <= evt_en_d;
      en_prev_q   <= cfg_en_i;
      irq_q       <= irq_d;
    end
  end

  // Read mux: reserved words and absent channels fall through to zero.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit_saddr[c]) rdata = 32'(cfg_curr_addr_i[c]);
      if (hit_size[c])  rdata = 32'(cfg_bytes_left_i[c]);
      if (hit_cfg[c])   rdata = {24'h0, bp_q[c], 1'b0, cfg_pending_i[c], cfg_en_i[c],
                                 1'b0, ds_q[c], cont_q[c]};
    end
    if (bus.cfg_addr_i == REG_STATUS) rdata = {16'h0, 8'(count), 6'h0, status_i};
    if (bus.cfg_addr_i == REG_EVT)    rdata = 32'(evt_q);
    if (bus.cfg_addr_i == REG_EVT_EN) rdata = 32'(evt_en_q);
  end

  assign bus.cfg_data_o = rdata;

  assign cfg_startaddr_o    = startaddr_q;
  assign cfg_size_o         = size_q;
  assign cfg_datasize_o     = ds_q;
  assign cfg_continuous_o   = cont_q;
  assign cfg_en_o           = en_q;
  assign cfg_clr_o          = clr_q;
  assign cfg_backpressure_o = bp_q;
  assign irq_o              = irq_q;

  assign unused_bits = ^{wdata[31:8], bus.udma_cmd_i[23:PAYLOAD_W]};
endmodule

// File: tb/tb_udma_spim_reg_if_mc.sv
// Directed bench for udma_spim_reg_if_mc with hand-computed expectations.
module tb_udma_spim_reg_if_mc;
  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udma_spim_reg_if_mc_if bus();

  logic [NCH-1:0][11:0] startaddr, curr_addr;
  logic [NCH-1:0][15:0] size, bytes_left;
  logic [NCH-1:0][1:0]  ds;
  logic [NCH-1:0]       cont, en_o, clr, bp, en_i, pending;
  logic [1:0]           status;
  logic                 irq;

  udma_spim_reg_if_mc dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .bus                (bus),
    .cfg_startaddr_o    (startaddr),
    .cfg_size_o         (size),
    .cfg_datasize_o     (ds),
    .cfg_continuous_o   (cont),
    .cfg_en_o           (en_o),
    .cfg_clr_o          (clr),
    .cfg_backpressure_o (bp),
    .cfg_en_i           (en_i),
    .cfg_pending_i      (pending),
    .cfg_curr_addr_i    (curr_addr),
    .cfg_bytes_left_i   (bytes_left),
    .status_i           (status),
    .irq_o              (irq)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    bus.cfg_addr_i  = a;
    bus.cfg_data_i  = d;
    bus.cfg_rwn_i   = 1'b0;
    bus.cfg_valid_i = 1'b1;
    tick();
    bus.cfg_valid_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    bus.cfg_addr_i  = a;
    bus.cfg_rwn_i   = 1'b1;
    bus.cfg_valid_i = 1'b1;
    #1;
    d = bus.cfg_data_o;
    bus.cfg_valid_i = 1'b0;
    bus.cfg_rwn_i   = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] w);
    bus.udma_cmd_i       = w;
    bus.udma_cmd_valid_i = 1'b1;
    tick();
    bus.udma_cmd_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] mk_cmd(input logic [3:0] code, input logic [1:0] ch,
                                         input logic [1:0] dsz, input logic [23:0] pl);
    return {code, ch, dsz, pl};
  endfunction

  localparam logic [3:0] UCA = 4'hD;
  localparam logic [3:0] UCS = 4'hE;

  logic [31:0] rd;
  int          n_pulse;
  int          pulse_cyc [4];
  logic [15:0] pulse_size [4];
  logic [NCH-1:0] en_seen;

  initial begin
    bus.cfg_data_i = '0; bus.cfg_addr_i = '0; bus.cfg_valid_i = 1'b0; bus.cfg_rwn_i = 1'b0;
    bus.udma_cmd_i = '0; bus.udma_cmd_valid_i = 1'b0; bus.udma_cmd_ready_i = 1'b1;
    en_i = '0; pending = '0; status = 2'b00;
    curr_addr = '0; bytes_left = '0;
    curr_addr[1] = 12'hABC;
    bytes_left[2] = 16'h0077;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cfg_read(5'h06, rd);  check("rst_cfg_ch1", rd, 32'h0000_0004);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cmd_ready", 32'(bus.udma_cmd_ready_o), 32'd1);
    cfg_read(5'h04, rd);  check("rd_saddr_ch1", rd, 32'h0000_0ABC);
    cfg_read(5'h09, rd);  check("rd_size_ch2", rd, 32'h0000_0077);
    cfg_read(5'h0C, rd);  check("rd_absent_ch3", rd, 32'h0);
    cfg_read(5'h13, rd);  check("rd_unmapped", rd, 32'h0);
    status = 2'b11;
    cfg_read(5'h10, rd);  check("rd_status_io", rd, 32'h0000_0003);
    status = 2'b00;

    // UCA then UCS on idle ch2; UCS accepted at edge T, en pulse in cycle T+2
    push_cmd(mk_cmd(UCA, 2'd2, 2'd0, 24'h000123));
    push_cmd(mk_cmd(UCS, 2'd2, 2'd0, 24'h000040));
    check("uca_startaddr2", 32'(startaddr[2]), 32'h123);
    check("ucs_en_t1", 32'(en_o), 32'h0);
    tick();
    check("ucs_en_t2", 32'(en_o), 32'h4);
    check("ucs_size2", 32'(size[2]), 32'h40);
    check("ucs_ds2", 32'(ds[2]), 32'h0);
    tick();
    check("ucs_en_t3", 32'(en_o), 32'h0);

    // Bad channel and unknown code are consumed without queuing
    push_cmd(mk_cmd(UCS, 2'd3, 2'd0, 24'h000010));
    push_cmd(mk_cmd(4'h1, 2'd0, 2'd0, 24'h000010));
    cfg_read(5'h10, rd);  check("discard_count", rd, 32'h0);

    // Fill the queue behind a pending channel, then release
    pending[1] = 1'b1;
    for (int i = 1; i <= 4; i++) push_cmd(mk_cmd(UCS, 2'd1, 2'd1, 24'(i)));
    check("full_ready", 32'(bus.udma_cmd_ready_o), 32'd0);
    cfg_read(5'h10, rd);  check("full_count", rd, 32'h0000_0400);
    check("stall_en", 32'(en_o), 32'h0);
    pending[1] = 1'b0;
    n_pulse = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (en_o[1]) begin
        if (n_pulse < 4) begin
          pulse_cyc[n_pulse]  = cyc;
          pulse_size[n_pulse] = size[1];
        end
        n_pulse++;
      end
    end
    check("drain_pulses", 32'(n_pulse), 32'd4);
    for (int i = 0; i < 4 && i < n_pulse; i++) begin
      check("drain_size", 32'(pulse_size[i]), 32'(i + 1));
      if (i > 0) check("drain_gap", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd3);
    end
    check("drain_ds1", 32'(ds[1]), 32'd1);

    // Done events and irq
    cfg_write(5'h12, 32'h4);
    en_i = 3'b100; tick();
    en_i = 3'b000; tick();
    cfg_read(5'h11, rd);  check("evt_set", rd, 32'h4);
    check("irq_lag", 32'(irq), 32'd0);
    tick();
    check("irq_set", 32'(irq), 32'd1);
    cfg_write(5'h11, 32'h4);
    cfg_read(5'h11, rd);  check("evt_w1c", rd, 32'h0);
    tick();
    check("irq_clr", 32'(irq), 32'd0);
    en_i = 3'b100; tick();
    en_i = 3'b000;
    cfg_write(5'h11, 32'h4);
    cfg_read(5'h11, rd);  check("evt_set_wins", rd, 32'h4);
    cfg_write(5'h11, 32'h4);

    // Command accepted in the same cycle as a cfg write to ch1 SIZE
    bus.cfg_addr_i = 5'h05; bus.cfg_data_i = 32'h1234;
    bus.cfg_rwn_i = 1'b0; bus.cfg_valid_i = 1'b1;
    bus.udma_cmd_i = mk_cmd(UCA, 2'd0, 2'd0, 24'h000055);
    bus.udma_cmd_valid_i = 1'b1;
    #1;
    check("collide_ready", 32'(bus.cfg_ready_o), 32'd0);
    tick();
    bus.udma_cmd_valid_i = 1'b0;
    #1;
    check("collide_hold", 32'(size[1]), 32'h4);
    check("retry_ready", 32'(bus.cfg_ready_o), 32'd1);
    tick();
    bus.cfg_valid_i = 1'b0;
    check("retry_size1", 32'(size[1]), 32'h1234);
    check("retry_uca0", 32'(startaddr[0]), 32'h55);

    // Clear flushes stalled entries
    pending[0] = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(mk_cmd(UCS, 2'd0, 2'd0, 24'h000008));
    cfg_read(5'h10, rd);  check("stall3_count", rd, 32'h0000_0300);
    cfg_write(5'h02, 32'h40);
    check("clr_pulse", 32'(clr), 32'h1);
    cfg_read(5'h10, rd);  check("clr_count", rd, 32'h0);
    tick();
    check("clr_end", 32'(clr), 32'h0);
    pending[0] = 1'b0;
    en_seen = '0;
    for (int i = 0; i < 4; i++) begin tick(); en_seen |= en_o; end
    check("clr_no_en", 32'(en_seen), 32'h0);

    // Reset mid-queue
    pending[0] = 1'b1;
    push_cmd(mk_cmd(UCS, 2'd0, 2'd0, 24'h000008));
    push_cmd(mk_cmd(UCS, 2'd0, 2'd0, 24'h000009));
    cfg_write(5'h12, 32'h7);
    cfg_write(5'h0A, 32'h81);
    check("pre_rst_bp", 32'(bp), 32'h4);
    rst = 1'b1; tick(); rst = 1'b0;
    pending[0] = 1'b0;
    cfg_read(5'h10, rd);  check("rst2_count", rd, 32'h0);
    cfg_read(5'h12, rd);  check("rst2_evt_en", rd, 32'h0);
    cfg_read(5'h0A, rd);  check("rst2_cfg_ch2", rd, 32'h0000_0004);
    check("rst2_startaddr2", 32'(startaddr[2]), 32'h0);
    check("rst2_size1", 32'(size[1]), 32'h0);
    check("rst2_ready", 32'(bus.udma_cmd_ready_o), 32'd1);
    en_seen = '0;
    for (int i = 0; i < 4; i++) begin tick(); en_seen |= en_o; end
    check("rst2_no_en", 32'(en_seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
